pe_sched: RTL and testbench

- Job sequencer and accumulator for one sparse-DNN PE (one 8-bit activation broadcast to MFU_COUNT MFUs).
- Accepts a job (precision mode, reduction length).
- Pulls activation/weight pairs from two valid/ready streams and registers them.
- Expands each weight into the per-MFU 32-bit replicated format, drives the PE, accumulates its outputs lane-wise, and presents the final sums on a valid/ready result port. The PE itself stays outside this block.

---
 rtl/pe_sched.sv | 145 ++++++++++++++
 tb/tb_pe_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sched.sv
// Job sequencer and lane-wise accumulator for one sparse-DNN PE: pulls paired
// activation/weight beats, expands weights per precision mode, sums PE lanes.
module pe_sched #(
  parameter int MFU_COUNT = 4,
  parameter int LEN_W     = 10,
  parameter int ACC_W     = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [LEN_W-1:0]               len,
  output logic                           busy,
  input  logic                           a_valid,
  input  logic [7:0]                     a_data,
  output logic                           a_ready,
  input  logic                           w_valid,
  input  logic [MFU_COUNT*16-1:0]        w_data,
  output logic                           w_ready,
  output logic [7:0]                     pe_a,
  output logic [MFU_COUNT*32-1:0]        pe_w,
  input  logic [MFU_COUNT*64-1:0]        pe_o,
  output logic                           res_valid,
  output logic [MFU_COUNT*4*ACC_W-1:0]   res_data,
  input  logic                           res_ready,
  output logic [1:0]                     state_dbg
);

  localparam int LANES = MFU_COUNT * 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     mode_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         count_q;
  logic                     s1_valid;
  logic                     fire;
  logic                     job_start;
  logic [LANES*ACC_W-1:0]   acc_q, acc_d;

  // Handshake: a_ready/w_ready are asserted together and only while both
  // streams are valid and pairs remain, so a beat moves on both streams at
  // once. Ready depends on valid; producers must not make valid depend on ready.
  assign fire      = (state_q == S_RUN) && (count_q != len_q) && a_valid && w_valid;
  assign job_start = (state_q == S_IDLE) && start;

  assign a_ready   = fire;
  assign w_ready   = fire;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign state_dbg = state_q;

  // Mode 0 replicates the low byte into all four lanes; mode 1 feeds the high
  // byte to the upper two lanes and the low byte to the lower two.
  function automatic logic [MFU_COUNT*32-1:0] expand_w(input logic m,
                                                      input logic [MFU_COUNT*16-1:0] raw);
    logic [7:0] lo;
    logic [7:0] hi;
    expand_w = '0;
    for (int i = 0; i < MFU_COUNT; i++) begin
      lo = raw[i*16 +: 8];
      hi = raw[i*16+8 +: 8];
      expand_w[i*32 +: 32] = m ? {hi, hi, lo, lo} : {lo, lo, lo, lo};
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (fire && ((count_q + LEN_W'(1)) == len_q)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      len_q   <= '0;
      count_q <= '0;
    end else if (job_start) begin
      mode_q  <= mode;
      len_q   <= len;
      count_q <= '0;
    end else if (fire) begin
      count_q <= count_q + LEN_W'(1);
    end
  end

  // Stage 1: register the fired pair towards the PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      pe_a     <= '0;
      pe_w     <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        pe_a <= a_data;
        pe_w <= expand_w(mode_q, w_data);
      end
    end
  end

  // Stage 2: add each signed 16-bit PE lane into its accumulator, wrapping.
  always_comb begin
    logic signed [15:0] lane;
    lane  = '0;
    acc_d = acc_q;
    if (job_start) begin
      acc_d = '0;
    end else if (s1_valid) begin
      for (int k = 0; k < LANES; k++) begin
        lane = pe_o[k*16 +: 16];
        acc_d[k*ACC_W +: ACC_W] = acc_q[k*ACC_W +: ACC_W] + ACC_W'(lane);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_pe_sched.sv
// Randomized and directed bench for pe_sched; a behavioural PE drives pe_o and a
// reference model sums the expected lanes from the raw job data.
module tb_pe_sched;

  localparam int MFU   = 4;
  localparam int LEN_W = 10;
  localparam int ACC_W = 24;
  localparam int RW    = MFU*4*ACC_W;
  localparam int RW16  = MFU*4*16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 mode;
  logic [LEN_W-1:0]     len;
  logic                 busy, busy16;
  logic                 a_valid;
  logic [7:0]           a_data;
  logic                 a_ready, a_ready16;
  logic                 w_valid;
  logic [MFU*16-1:0]    w_data;
  logic                 w_ready, w_ready16;
  logic [7:0]           pe_a, pe_a16;
  logic [MFU*32-1:0]    pe_w, pe_w16;
  logic [MFU*64-1:0]    pe_o, pe_o16;
  logic                 res_valid, res_valid16;
  logic [RW-1:0]        res_data;
  logic [RW16-1:0]      res_data16;
  logic                 res_ready;
  logic [1:0]           state_dbg, state_dbg16;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0]        exp_q[$];
  logic [7:0]           job_a[$];
  logic [MFU*16-1:0]    job_w[$];

  // Behavioural PE: either lane j = signed(a) * signed(weight byte j), or a
  // lookup table indexed by the activation for directed lane values.
  logic                 sel_lut;
  logic signed [15:0]   lut[16];

  always #5 clk = ~clk;

  pe_sched #(.MFU_COUNT(MFU), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .busy(busy),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .pe_a(pe_a), .pe_w(pe_w), .pe_o(pe_o),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .state_dbg(state_dbg)
  );

  pe_sched #(.MFU_COUNT(MFU), .LEN_W(LEN_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .busy(busy16),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready16),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready16),
    .pe_a(pe_a16), .pe_w(pe_w16), .pe_o(pe_o16),
    .res_valid(res_valid16), .res_data(res_data16), .res_ready(res_ready),
    .state_dbg(state_dbg16)
  );

  always_comb begin
    logic signed [15:0] v;
    logic signed [15:0] v16;
    v = '0;
    v16 = '0;
    pe_o = '0;
    pe_o16 = '0;
    for (int i = 0; i < MFU; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sel_lut) begin
          v   = lut[pe_a[3:0]];
          v16 = lut[pe_a16[3:0]];
        end else begin
          v   = $signed(pe_a)   * $signed(pe_w[i*32+j*8 +: 8]);
          v16 = $signed(pe_a16) * $signed(pe_w16[i*32+j*8 +: 8]);
        end
        pe_o[(i*4+j)*16 +: 16]   = v;
        pe_o16[(i*4+j)*16 +: 16] = v16;
      end
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected PE weight word for one raw beat: lanes 0,1 always take the low
  // byte; lanes 2,3 take the high byte only in 4x4 mode.
  function automatic logic [MFU*32-1:0] expand_ref(input logic m, input logic [MFU*16-1:0] raw);
    logic [15:0] r;
    expand_ref = '0;
    for (int i = 0; i < MFU; i++) begin
      r = raw[i*16 +: 16];
      for (int j = 0; j < 4; j++)
        expand_ref[i*32+j*8 +: 8] = (m && j >= 2) ? r[15:8] : r[7:0];
    end
  endfunction

  // Reference sums over the whole job with plain integer arithmetic, then
  // truncated to each accumulator width.
  task automatic push_expected(input logic m);
    logic [RW-1:0]   e24;
    logic [RW16-1:0] e16;
    logic [15:0]     r;
    logic [7:0]      b;
    int              s;
    e24 = '0;
    e16 = '0;
    for (int k = 0; k < MFU*4; k++) begin
      s = 0;
      for (int p = 0; p < job_a.size(); p++) begin
        if (sel_lut) begin
          s += int'(lut[job_a[p][3:0]]);
        end else begin
          r = job_w[p][(k/4)*16 +: 16];
          b = (m && (k%4) >= 2) ? r[15:8] : r[7:0];
          s += int'($signed(job_a[p])) * int'($signed(b));
        end
      end
      e24[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
      e16[k*16 +: 16]       = s[15:0];
    end
    exp_q.push_back(e24);
    exp_q.push_back(RW'(e16));
  endtask

  // stall: 0 full rate, 1 random bubbles, 2 w_valid pattern 1,0,0.
  task automatic run_job(input logic m, input int stall, input int abort_after, input int hold);
    int              n, k, t, edges;
    logic            av, wv;
    logic [7:0]      last_a;
    logic [MFU*32-1:0] last_w;
    logic [RW-1:0]   e24, e16;
    n = job_a.size();
    last_a = '0;
    last_w = '0;
    if (abort_after == 0) push_expected(m);
    @(negedge clk);
    mode = m; len = LEN_W'(n); start = 1'b1; res_ready = 1'b0;
    a_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    check("busy_after_start", RW'(busy), RW'(1));
    k = 0;
    t = 0;
    while (k < n && t < 4000) begin
      if (k > 0) begin
        check("pe_a_hold", RW'(pe_a), RW'(last_a));
        check("pe_w_hold", RW'(pe_w), RW'(last_w));
      end
      case (stall)
        0:       begin av = 1'b1; wv = 1'b1; end
        1:       begin av = ($urandom_range(0, 3) != 0); wv = ($urandom_range(0, 3) != 0); end
        default: begin av = 1'b1; wv = ((t % 3) == 0); end
      endcase
      a_data = job_a[k]; w_data = job_w[k]; a_valid = av; w_valid = wv;
      #1;
      check("a_ready", RW'(a_ready), RW'(av && wv));
      check("w_ready", RW'(w_ready), RW'(av && wv));
      if (av && wv) begin
        last_a = job_a[k];
        last_w = expand_ref(m, job_w[k]);
        k++;
        if (k == abort_after) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1;
          check("abort_busy", RW'(busy), RW'(0));
          check("abort_a_ready", RW'(a_ready), RW'(0));
          check("abort_res_valid", RW'(res_valid), RW'(0));
          check("abort_pe_a", RW'(pe_a), RW'(0));
          check("abort_res_data", res_data, RW'(0));
          a_valid = 1'b0; w_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      t++;
      @(negedge clk);
      edges++;
    end
    if (t >= 4000) check("drive_budget", RW'(0), RW'(1));
    if (n > 0) begin
      check("pe_a_last", RW'(pe_a), RW'(last_a));
      check("pe_w_last", RW'(pe_w), RW'(last_w));
    end
    a_valid = 1'b1; w_valid = 1'b1;
    a_data = 8'($urandom); w_data = {$urandom, $urandom};
    t = 0;
    while (!res_valid && t < 20) begin
      #1;
      check("no_extra_fire", RW'(a_ready), RW'(0));
      @(negedge clk);
      edges++;
      t++;
    end
    check("res_valid", RW'(res_valid), RW'(1));
    if (stall == 0) check("latency", RW'(edges), RW'((n == 0) ? 1 : n + 2));
    e24 = exp_q.pop_front();
    e16 = exp_q.pop_front();
    check("res_data", res_data, e24);
    check("res_data16", RW'(res_data16), e16);
    a_valid = 1'b0; w_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      len   = LEN_W'($urandom_range(1, 20));
      @(negedge clk);
      check("hold_valid", RW'(res_valid), RW'(1));
      check("hold_data", res_data, e24);
      check("hold_data16", RW'(res_data16), e16);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_drop", RW'(res_valid), RW'(0));
    check("res_drop16", RW'(res_valid16), RW'(0));
    check("busy_idle", RW'(busy), RW'(0));
  endtask

  task automatic new_job();
    job_a.delete();
    job_w.delete();
  endtask

  initial begin
    logic [MFU*16-1:0] w;
    rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
    a_valid = 1'b0; a_data = '0; w_valid = 1'b0; w_data = '0; res_ready = 1'b0;
    sel_lut = 1'b0;
    for (int i = 0; i < 16; i++) lut[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_a_ready", RW'(a_ready), RW'(0));
    check("rst_res_valid", RW'(res_valid), RW'(0));
    check("rst_pe_a", RW'(pe_a), RW'(0));
    check("rst_pe_w", RW'(pe_w), RW'(0));
    check("rst_res_data", res_data, RW'(0));
    rst = 1'b0;

    // Weight expansion in both modes.
    for (int m = 0; m < 2; m++) begin
      new_job();
      w = {$urandom, $urandom};
      w[15:0] = 16'h12AB;
      job_a.push_back(8'h03);
      job_w.push_back(w);
      run_job(1'(m), 0, 0, 0);
      check("exp_pe_a", RW'(pe_a), RW'(8'h03));
      check("exp_pe_w0", RW'(pe_w[31:0]), RW'((m == 0) ? 32'hABABABAB : 32'h1212ABAB));
    end

    // Full-rate accumulate: every lane 5, three pairs.
    sel_lut = 1'b1;
    lut[1] = 16'sd5; lut[2] = 16'sh7FFF; lut[3] = 16'sd1;
    lut[4] = -16'sd3; lut[5] = -16'sd4; lut[6] = 16'sd7;
    new_job();
    for (int i = 0; i < 3; i++) begin job_a.push_back(8'd1); job_w.push_back({$urandom, $urandom}); end
    run_job(1'b0, 0, 0, 0);
    check("lane15", RW'(res_data[ACC_W-1:0]), RW'(15));

    // Signed wrap in the 16-bit accumulator, and negative sums.
    new_job();
    job_a.push_back(8'd2); job_w.push_back('0);
    job_a.push_back(8'd3); job_w.push_back('0);
    run_job(1'b0, 0, 0, 0);
    check("wrap16", RW'(res_data16[15:0]), RW'(16'h8000));
    new_job();
    job_a.push_back(8'd4); job_w.push_back('0);
    job_a.push_back(8'd5); job_w.push_back('0);
    run_job(1'b1, 0, 0, 0);
    check("neg7", RW'(res_data[ACC_W-1:0]), RW'(24'hFFFFF9));

    // Stall pattern on w_valid, product PE.
    sel_lut = 1'b0;
    new_job();
    for (int i = 0; i < 4; i++) begin job_a.push_back(8'($urandom)); job_w.push_back({$urandom, $urandom}); end
    run_job(1'b1, 2, 0, 2);

    // Zero length with a long hold and ignored start pulses.
    new_job();
    run_job(1'b0, 0, 0, 10);

    // Reset after two of five fires, then a clean single-pair job.
    new_job();
    for (int i = 0; i < 5; i++) begin job_a.push_back(8'($urandom)); job_w.push_back({$urandom, $urandom}); end
    run_job(1'b0, 0, 2, 0);
    sel_lut = 1'b1;
    new_job();
    job_a.push_back(8'd6); job_w.push_back({$urandom, $urandom});
    run_job(1'b0, 0, 0, 0);
    check("post_abort7", RW'(res_data[ACC_W-1:0]), RW'(7));

    // Random jobs against the reference model.
    sel_lut = 1'b0;
    for (int r = 0; r < 25; r++) begin
      new_job();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) begin
        job_a.push_back(8'($urandom));
        job_w.push_back({$urandom, $urandom});
      end
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
